// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared depth, entry type and operation encoding for the store buffer
package store_buffer_pkg;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_LOAD,
        OP_STORE
    } sb_op_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: execute-side request and memory-stage result signals of the store buffer
interface store_buffer_if;
    logic        exe_mem_r_en;
    logic        exe_mem_w_en;
    logic [31:0] exe_alu_res;
    logic [31:0] exe_st_value;
    logic        stall;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_res;
    logic [31:0] ST_value;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        sb_empty;

    modport master (
        output exe_mem_r_en, exe_mem_w_en, exe_alu_res, exe_st_value,
        input  stall, MEM_R_EN, MEM_W_EN, ALU_res, ST_value, fwd_hit, fwd_data, sb_empty
    );

    modport slave (
        input  exe_mem_r_en, exe_mem_w_en, exe_alu_res, exe_st_value,
        output stall, MEM_R_EN, MEM_W_EN, ALU_res, ST_value, fwd_hit, fwd_data, sb_empty
    );
endinterface

// File: rtl/store_buffer_fifo.sv
// store_buf_fifo: circular store entry array with push/pop, count and age-ordered word-address match vector
module store_buf_fifo
    import store_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  sb_entry_t               push_entry,
    input  logic [29:0]             match_addr,
    output sb_entry_t               head_entry,
    output logic [PTR_W:0]          count,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH-1:0]        match,
    output sb_entry_t [DEPTH-1:0]   age_ent
);
    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop) head <= head + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end

    // Entry storage needs no reset: only entries below count are ever observed
    always_ff @(posedge clk)
        if (push) mem[tail] <= push_entry;

    assign head_entry = mem[head];
    assign full       = count == (PTR_W+1)'(DEPTH);
    assign empty      = count == '0;

    // Age 0 is the oldest entry; a match bit is only set for valid entries
    always_comb
        for (int i = 0; i < DEPTH; i++) begin
            age_ent[i] = mem[head + PTR_W'(i)];
            match[i]   = (PTR_W+1)'(i) < count && age_ent[i].addr[31:2] == match_addr;
        end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: 4-entry store buffer and EXE->MEM register; STORE_FWD_EN enables load forwarding
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);
    sb_op_t          op;
    sb_entry_t       new_ent;
    sb_entry_t       head_ent;
    logic [DEPTH-1:0] match;
    logic [PTR_W:0]  count;
    logic            full;
    logic            empty;
    logic            ld_block;
    logic            load_go;
    logic            push;
    logic            pop;

    assign new_ent = '{addr: bus.exe_alu_res, data: bus.exe_st_value};

`ifdef STORE_FWD_EN
    sb_entry_t [DEPTH-1:0] age_ent;
    logic                  hit;
    logic [31:0]           hit_data;
`endif

    store_buf_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_entry (new_ent),
        .match_addr (bus.exe_alu_res[31:2]),
        .head_entry (head_ent),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .match      (match),
`ifdef STORE_FWD_EN
        .age_ent    (age_ent)
`else
        .age_ent    ()
`endif
    );

    // Decode the operation; the port goes to an accepted load, else drains whenever no store is enqueued
    always_comb begin
        op = bus.exe_mem_w_en ? OP_STORE : bus.exe_mem_r_en ? OP_LOAD : OP_IDLE;
`ifdef STORE_FWD_EN
        ld_block = 1'b0;
`else
        ld_block = op == OP_LOAD && |match;
`endif
        load_go = op == OP_LOAD && !ld_block;
        push    = op == OP_STORE && !full;
        pop     = !empty && !load_go && !push;
    end

    assign bus.stall = (op == OP_STORE && full) || ld_block;

    // Memory-stage register: one access per cycle, address and data hold when nothing issues
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bus.MEM_R_EN <= 1'b0;
            bus.MEM_W_EN <= 1'b0;
            bus.ALU_res  <= '0;
            bus.ST_value <= '0;
            bus.sb_empty <= 1'b1;
        end else begin
            bus.MEM_R_EN <= load_go;
            bus.MEM_W_EN <= pop;
            if (load_go) bus.ALU_res <= bus.exe_alu_res;
            else if (pop) bus.ALU_res <= head_ent.addr;
            if (pop) bus.ST_value <= head_ent.data;
            bus.sb_empty <= !push && (empty || (pop && count == (PTR_W+1)'(1)));
        end

`ifdef STORE_FWD_EN
    // Youngest matching entry wins: later ages overwrite earlier ones
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (match[i]) begin
                hit      = 1'b1;
                hit_data = age_ent[i].data;
            end
    end

    // Forwarding result travels with the load; data holds when the load misses
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bus.fwd_hit  <= 1'b0;
            bus.fwd_data <= '0;
        end else begin
            bus.fwd_hit <= load_go && hit;
            if (load_go && hit) bus.fwd_data <= hit_data;
        end
`else
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = '0;
`endif
endmodule
